// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: 4-bit sequential calculator with a multiplexed 3-digit
// 7-segment readout.
//
// An operation is started from IDLE and walks IDLE -> CALC -> CONV -> DONE.
// CALC evaluates add/sub/mul/div in one cycle. CONV runs an 8-step
// shift-and-add-3 binary-to-BCD conversion. DONE publishes the new value to
// the display registers in a single cycle.
//
// A free-running scan rotates the digit select every SCAN_DIV cycles.
// The scan is independent of the FSM.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   a, b       4-bit unsigned operands, latched when start is accepted
//   op         00 add, 01 subtract, 10 multiply, 11 divide
//   start      request, only sampled in IDLE (no queuing)
//   busy       operation in progress
//   done       one-cycle pulse when a new result reaches the display
//   result     magnitude of the last displayed result
//   neg, err   last result negative / last result was a division by zero
//   seg        active-high segments {g,f,e,d,c,b,a} of the selected digit
//   an         one-hot digit select: 001 units, 010 tens, 100 hundreds
//   state_dbg  current FSM state (IDLE=0, CALC=1, CONV=2, DONE=3)
//
// Handshake: start is a level sampled on a rising edge only while the FSM is
// in IDLE. Once accepted, further start pulses are dropped until done has
// pulsed and the FSM is back in IDLE.
module alu_seq_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       neg,
  output logic       err,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, CONV = 2'd2, DONE = 2'd3} state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_BLANK = 7'b0000000;
  localparam logic [6:0]  SEG_MINUS = 7'b1000000;
  localparam logic [6:0]  SEG_E     = 7'b1111001;

  state_t      state;
  logic [3:0]  a_q, b_q;
  logic [1:0]  op_q;
  logic [7:0]  mag;          // magnitude kept for publishing in DONE
  logic [7:0]  shreg;        // binary bits still to be shifted into the BCD
  logic        neg_c, err_c; // flags of the operation in flight
  logic [11:0] bcd;          // {hundreds, tens, units}
  logic [2:0]  iter;
  logic [3:0]  disp_h, disp_t, disp_u;
  logic [15:0] scan_cnt;

  logic [7:0]  calc_mag;
  logic        calc_neg, calc_err;
  logic [11:0] bcd_adj;

  assign state_dbg = state;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Arithmetic on the latched operands; consumed in CALC.
  always_comb begin
    calc_mag = 8'd0;
    calc_neg = 1'b0;
    calc_err = 1'b0;
    case (op_q)
      2'b00: calc_mag = {4'b0, a_q} + {4'b0, b_q};
      2'b01: begin
        if (a_q >= b_q) begin
          calc_mag = {4'b0, a_q - b_q};
        end else begin
          calc_mag = {4'b0, b_q - a_q};
          calc_neg = 1'b1;
        end
      end
      2'b10: calc_mag = {4'b0, a_q} * {4'b0, b_q};
      default: begin
        if (b_q == 4'd0) calc_err = 1'b1;
        else             calc_mag = {4'b0, a_q / b_q};
      end
    endcase
  end

  // Each BCD digit is corrected before the shift so it carries correctly.
  assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      op_q   <= 2'd0;
      mag    <= 8'd0;
      shreg  <= 8'd0;
      neg_c  <= 1'b0;
      err_c  <= 1'b0;
      bcd    <= 12'd0;
      iter   <= 3'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 8'd0;
      neg    <= 1'b0;
      err    <= 1'b0;
      disp_h <= 4'd0;
      disp_t <= 4'd0;
      disp_u <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            state <= CALC;
          end
        end
        CALC: begin
          mag   <= calc_mag;
          shreg <= calc_mag;
          neg_c <= calc_neg;
          err_c <= calc_err;
          bcd   <= 12'd0;
          iter  <= 3'd0;
          busy  <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          bcd   <= {bcd_adj[10:0], shreg[7]};
          shreg <= {shreg[6:0], 1'b0};
          iter  <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
        end
        DONE: begin
          // All display-facing registers change together, never piecemeal.
          disp_h <= bcd[11:8];
          disp_t <= bcd[7:4];
          disp_u <= bcd[3:0];
          result <= mag;
          neg    <= neg_c;
          err    <= err_c;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit scan prescaler, free running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= 16'd0;
      an       <= 3'b001;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= 16'd0;
      an       <= {an[1:0], an[2]};
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // seg is decoded from the registered an, so the two never disagree.
  always_comb begin
    seg = SEG_BLANK;
    if (err) begin
      seg = SEG_E;
    end else begin
      case (an)
        3'b100:  seg = neg ? SEG_MINUS : ((disp_h == 4'd0) ? SEG_BLANK : seg_of(disp_h));
        3'b010:  seg = (disp_h == 4'd0 && disp_t == 4'd0) ? SEG_BLANK : seg_of(disp_t);
        default: seg = seg_of(disp_u);
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  localparam int SCAN = 4;

  localparam logic [6:0] BLANK = 7'b0000000;
  localparam logic [6:0] MINUS = 7'b1000000;
  localparam logic [6:0] ECHR  = 7'b1111001;

  typedef struct packed {
    logic [31:0] n;    // edge count at which start was accepted
    logic [7:0]  mag;
    logic        neg;
    logic        err;
    logic [6:0]  sh;
    logic [6:0]  st;
    logic [6:0]  su;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic [1:0] op = 2'd0;
  logic       start = 1'b0;
  logic       busy, done, neg, err;
  logic [7:0] result;
  logic [6:0] seg;
  logic [2:0] an;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edges since reset release, for the scan expectation.
  int k = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  alu_seq_ctrl #(.SCAN_DIV(SCAN)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
    .busy(busy), .done(done), .result(result), .neg(neg), .err(err),
    .seg(seg), .an(an), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t model(input int ia, input int ib, input int iop);
    exp_t e;
    int m, h, t, u;
    e = '0;
    m = 0;
    case (iop)
      0: m = ia + ib;
      1: begin
        m = (ia >= ib) ? ia - ib : ib - ia;
        e.neg = (ia < ib);
      end
      2: m = ia * ib;
      default: begin
        if (ib == 0) e.err = 1'b1;
        else         m = ia / ib;
      end
    endcase
    e.mag = 8'(m);
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    if (e.err) begin
      e.sh = ECHR; e.st = ECHR; e.su = ECHR;
    end else begin
      e.sh = e.neg ? MINUS : ((h == 0) ? BLANK : digit_seg(h));
      e.st = (h == 0 && t == 0) ? BLANK : digit_seg(t);
      e.su = digit_seg(u);
    end
    return e;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [6:0] m_h = BLANK, m_t = BLANK, m_u = 7'b0111111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [2:0] an_exp;
    logic [6:0] seg_exp;
    if (rst) begin
      m_h = BLANK; m_t = BLANK; m_u = 7'b0111111;
      exp_q.delete();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_neg", 32'(neg), 32'd0);
      check("rst_err", 32'(err), 32'd0);
    end else begin
      if (exp_q.size() > 0 && !done) begin
        e = exp_q[0];
        if (cyc >= int'(e.n) + 1 && cyc <= int'(e.n) + 9)
          check("busy_during_op", 32'(busy), 32'd1);
        if (cyc > int'(e.n) + 10) begin
          check("done_timeout", 32'(done), 32'd1);
          void'(exp_q.pop_front());
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_latency", 32'(cyc), e.n + 32'd10);
          check("result", 32'(result), 32'(e.mag));
          check("neg", 32'(neg), 32'(e.neg));
          check("err", 32'(err), 32'(e.err));
          check("busy_at_done", 32'(busy), 32'd0);
          m_h = e.sh; m_t = e.st; m_u = e.su;
        end
      end
    end
    case ((k / SCAN) % 3)
      0:       an_exp = 3'b001;
      1:       an_exp = 3'b010;
      default: an_exp = 3'b100;
    endcase
    seg_exp = (an_exp == 3'b100) ? m_h : (an_exp == 3'b010) ? m_t : m_u;
    check("an", 32'(an), 32'(an_exp));
    check("seg", 32'(seg), 32'(seg_exp));
  end

  // ---------------- driver ----------------
  task automatic issue(input int ia, input int ib, input int iop, input bit poke3);
    int n;
    int g;
    @(negedge clk);
    a = 4'(ia); b = 4'(ib); op = 2'(iop); start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    exp_q.push_back(model(ia, ib, iop) | exp_t'({32'(n), 31'd0}));
    g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
      // Extra start pulses while busy must be ignored; stop before DONE.
      if (cyc <= n + 7) begin
        start = poke3 ? (cyc == n + 2) : ($urandom_range(0, 3) == 0);
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        op = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  // Start an operation and kill it with reset five edges later.
  task automatic abort_op(input int ia, input int ib, input int iop);
    @(negedge clk);
    a = 4'(ia); b = 4'(ib); op = 2'(iop); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);   // watch a few scan rotations from release

    issue(7, 8, 0, 1'b0);
    issue(3, 9, 1, 1'b0);
    issue(15, 15, 2, 1'b0);
    issue(9, 0, 3, 1'b0);
    issue(12, 5, 1, 1'b1);
    abort_op(15, 15, 2);
    issue(0, 0, 0, 1'b0);
    issue(15, 1, 3, 1'b0);
    issue(10, 10, 1, 1'b0);
    for (int i = 0; i < 60; i++)
      issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 1'b0);
    abort_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
    issue(6, 7, 2, 1'b0);

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
